// File: rtl/fract_engine.sv
// fract_engine: Mandelbrot frame generator producing per-pixel escape-iteration
// counts. Pixels are produced in row-major order and written through a
// valid/ready port.
// Optional feature macro: FRACT_RESTART_EN. When it is defined, a start pulse
// during a frame aborts that frame and restarts with the newly presented view.
// When it is undefined, a start pulse during a frame is ignored.
module fract_engine #(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 28,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int ITER_BITS = 8,
    parameter int MAX_ITER  = 255,
    parameter int ADDR_BITS = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     centerx,
    input  logic [WIDTH-1:0]     centery,
    input  logic [WIDTH-1:0]     step,
    output logic                 wr_en,
    input  logic                 wr_ready,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [ITER_BITS-1:0] wr_data,
    output logic                 busy,
    output logic                 done
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int MW = 2 * WIDTH + 1;
    localparam int PW = 2 * WIDTH;

    localparam logic [XW-1:0]        X_LAST    = XW'(H_RES - 1);
    localparam logic [YW-1:0]        Y_LAST    = YW'(V_RES - 1);
    localparam logic [WIDTH-1:0]     HALF_COLS = WIDTH'(H_RES / 2);
    localparam logic [WIDTH-1:0]     HALF_ROWS = WIDTH'(V_RES / 2);
    localparam logic [ITER_BITS-1:0] K_LIMIT   = ITER_BITS'(MAX_ITER);
    // 4.0 expressed in the scale of a full-precision product (2*FRAC fraction bits)
    localparam logic [MW-1:0]        ESC_LIMIT = MW'(4) << (2 * FRAC);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PIXEL,
        ITER,
        WRITE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     cx_q, cx_d;
    logic [WIDTH-1:0]     cy_q, cy_d;
    logic [WIDTH-1:0]     step_q, step_d;
    logic [WIDTH-1:0]     cr0_q, cr0_d;
    logic [WIDTH-1:0]     cr_q, cr_d;
    logic [WIDTH-1:0]     ci_q, ci_d;
    logic [WIDTH-1:0]     zr_q, zr_d;
    logic [WIDTH-1:0]     zi_q, zi_d;
    logic [ITER_BITS-1:0] k_q, k_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ITER_BITS-1:0] data_q, data_d;

    logic signed [PW-1:0] zrExt, ziExt;
    logic signed [PW-1:0] zrSq, ziSq, zrZi;
    logic [MW-1:0]        magSq;
    logic                 escaped;
    logic [WIDTH-1:0]     zrNext, ziNext;
    logic                 accept;
    logic                 lastPix;
    logic                 busyInt;
    logic                 unusedZrZi;

    // Full-precision squares and cross product of the current z
    assign zrExt = PW'($signed(zr_q));
    assign ziExt = PW'($signed(zi_q));
    assign zrSq  = zrExt * zrExt;
    assign ziSq  = ziExt * ziExt;
    assign zrZi  = zrExt * ziExt;

    // Both squares are non-negative, so zero extension gives an exact magnitude
    assign magSq   = {1'b0, zrSq} + {1'b0, ziSq};
    assign escaped = magSq > ESC_LIMIT;

    // Doubling the cross product is folded into the bit selection one place lower
    assign zrNext = zrSq[WIDTH+FRAC-1:FRAC] - ziSq[WIDTH+FRAC-1:FRAC] + cr_q;
    assign ziNext = zrZi[WIDTH+FRAC-2:FRAC-1] + ci_q;

    assign unusedZrZi = ^{zrZi[PW-1:WIDTH+FRAC-1], zrZi[FRAC-2:0]};

    assign accept  = (state_q == WRITE) && wr_ready;
    assign lastPix = (x_q == X_LAST) && (y_q == Y_LAST);
    assign busyInt = (state_q == SETUP) || (state_q == PIXEL) ||
                     (state_q == ITER)  || (state_q == WRITE);

    assign wr_en   = (state_q == WRITE);
    assign wr_addr = addr_q;
    assign wr_data = data_q;
    assign busy    = busyInt;
    assign done    = (state_q == DONE);

    // Next-state and datapath update for the frame sequencer
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        step_d  = step_q;
        cr0_d   = cr0_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cx_d    = centerx;
                    cy_d    = centery;
                    step_d  = step;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cr0_d   = cx_q - HALF_COLS * step_q;
                cr_d    = cx_q - HALF_COLS * step_q;
                ci_d    = cy_q + HALF_ROWS * step_q;
                x_d     = '0;
                y_d     = '0;
                addr_d  = '0;
                state_d = PIXEL;
            end
            PIXEL: begin
                zr_d    = '0;
                zi_d    = '0;
                k_d     = '0;
                state_d = ITER;
            end
            ITER: begin
                if (escaped || (k_q == K_LIMIT)) begin
                    data_d  = k_q;
                    state_d = WRITE;
                end else begin
                    zr_d = zrNext;
                    zi_d = ziNext;
                    k_d  = k_q + ITER_BITS'(1);
                end
            end
            WRITE: begin
                if (accept) begin
                    addr_d = addr_q + ADDR_BITS'(1);
                    if (lastPix) begin
                        state_d = DONE;
                    end else begin
                        state_d = PIXEL;
                        if (x_q != X_LAST) begin
                            x_d  = x_q + XW'(1);
                            cr_d = cr_q + step_q;
                        end else begin
                            x_d  = '0;
                            cr_d = cr0_q;
                            y_d  = y_q + YW'(1);
                            ci_d = ci_q - step_q;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef FRACT_RESTART_EN
        // A mid-frame start abandons the frame, except when it coincides with the final accept
        if (start && busyInt && !(accept && lastPix)) begin
            cx_d    = centerx;
            cy_d    = centery;
            step_d  = step;
            state_d = SETUP;
        end
`endif
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            step_q  <= '0;
            cr0_q   <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            step_q  <= step_d;
            cr0_q   <= cr0_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_fract_engine.sv
// tb_fract_engine: directed, table-driven bench for fract_engine on a 4x2 frame.
module tb_fract_engine;

    localparam int WIDTH     = 32;
    localparam int FRAC      = 28;
    localparam int H_RES     = 4;
    localparam int V_RES     = 2;
    localparam int ITER_BITS = 8;
    localparam int MAX_ITER  = 255;
    localparam int ADDR_BITS = 8;
    localparam int NPIX      = H_RES * V_RES;

    // Q4.28 constants
    localparam logic [31:0] FX_ZERO  = 32'h0000_0000;
    localparam logic [31:0] FX_ONE   = 32'h1000_0000;
    localparam logic [31:0] FX_THREE = 32'h3000_0000;
    localparam logic [31:0] FX_MONE  = 32'hF000_0000;

    typedef struct packed {
        logic [31:0]           cx;
        logic [31:0]           cy;
        logic [31:0]           st;
        logic [NPIX-1:0][7:0]  data;
    } vec_t;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     centerx;
    logic [WIDTH-1:0]     centery;
    logic [WIDTH-1:0]     step;
    logic                 wr_en;
    logic                 wr_ready;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [ITER_BITS-1:0] wr_data;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int errors = 0;

    int gotAddr[$];
    int gotData[$];
    int expAddr[$];
    int expData[$];
    int doneCount;
    int doneCycle;
    int lastAcceptCycle;
    int extraWrites;

    vec_t vecs[4];

    fract_engine #(
        .WIDTH(WIDTH), .FRAC(FRAC), .H_RES(H_RES), .V_RES(V_RES),
        .ITER_BITS(ITER_BITS), .MAX_ITER(MAX_ITER), .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .centerx(centerx), .centery(centery), .step(step),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic [31:0] cx, input logic [31:0] cy,
                                   input logic [31:0] st, input logic [NPIX-1:0][7:0] d);
        vec_t v;
        v.cx   = cx;
        v.cy   = cy;
        v.st   = st;
        v.data = d;
        return v;
    endfunction

    task automatic applyStimulus(input logic [31:0] cx, input logic [31:0] cy, input logic [31:0] st);
        @(negedge clk);
        centerx  = cx;
        centery  = cy;
        step     = st;
        wr_ready = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyAfterStart", busy, 1);
    endtask

    // Runs one frame, optionally stalling at stallAddr for 5 cycles or pulsing start at restartAddr
    task automatic collectFrame(input int stallAddr, input logic [7:0] stallData, input int restartAddr,
                                input logic [31:0] rcx, input logic [31:0] rcy, input logic [31:0] rstep);
        int  cycles    = 0;
        int  stallLeft = 5;
        bit  restarted = 1'b0;
        bit  finished  = 1'b0;
        gotAddr.delete();
        gotData.delete();
        doneCount       = 0;
        doneCycle       = -1;
        lastAcceptCycle = -1;
        extraWrites     = 0;
        while (!finished && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            start    = 1'b0;
            wr_ready = 1'b1;
            if (stallAddr >= 0 && stallLeft > 0 &&
                (stallLeft < 5 || (wr_en && wr_addr == ADDR_BITS'(stallAddr)))) begin
                wr_ready = 1'b0;
                checkOutput("stallWrEn", wr_en, 1);
                checkOutput("stallAddr", wr_addr, stallAddr);
                checkOutput("stallData", wr_data, stallData);
                stallLeft--;
            end
            if (restartAddr >= 0 && !restarted && wr_en && wr_addr == ADDR_BITS'(restartAddr)) begin
                wr_ready  = 1'b0;
                start     = 1'b1;
                centerx   = rcx;
                centery   = rcy;
                step      = rstep;
                restarted = 1'b1;
            end
            if (wr_en && wr_ready) begin
                gotAddr.push_back(int'(wr_addr));
                gotData.push_back(int'(wr_data));
                lastAcceptCycle = cycles;
            end
            if (done) begin
                doneCount++;
                doneCycle = cycles;
                finished  = 1'b1;
            end
        end
        start = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL frameTimeout: got no done pulse, expected one within 20000 cycles");
        end
        repeat (3) begin
            @(negedge clk);
            if (done) doneCount++;
            if (wr_en) extraWrites++;
        end
    endtask

    task automatic verifyFrame();
        checkOutput("writeCount", gotAddr.size(), expAddr.size());
        for (int i = 0; i < expAddr.size(); i++) begin
            if (i < gotAddr.size()) begin
                checkOutput($sformatf("addr[%0d]", i), gotAddr[i], expAddr[i]);
                checkOutput($sformatf("data[%0d]", i), gotData[i], expData[i]);
            end
        end
        checkOutput("donePulses", doneCount, 1);
        checkOutput("doneLatency", doneCycle, lastAcceptCycle + 1);
        checkOutput("extraWrites", extraWrites, 0);
        checkOutput("busyAfterFrame", busy, 0);
    endtask

    task automatic expectPlain(input vec_t v);
        expAddr.delete();
        expData.delete();
        for (int i = 0; i < NPIX; i++) begin
            expAddr.push_back(i);
            expData.push_back(int'(v.data[i]));
        end
    endtask

    initial begin
        int activity;
        bit sawWrEn;

        // Expected counts, written as {addr7 .. addr0}
        vecs[0] = mkVec(FX_ZERO, FX_ZERO, FX_ZERO,
                        {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255});
        vecs[1] = mkVec(FX_THREE, FX_ZERO, FX_ZERO,
                        {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1});
        vecs[2] = mkVec(FX_MONE, FX_ZERO, FX_ZERO,
                        {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255});
        // Row 0 c = (-2,1),(-1,1),(0,1),(1,1); row 1 c = (-2,0),(-1,0),(0,0),(1,0)
        vecs[3] = mkVec(FX_ZERO, FX_ZERO, FX_ONE,
                        {8'd3, 8'd255, 8'd255, 8'd255, 8'd2, 8'd255, 8'd3, 8'd1});

        rst      = 1'b1;
        start    = 1'b0;
        centerx  = '0;
        centery  = '0;
        step     = '0;
        wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("resetWrEn", wr_en, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetAddr", wr_addr, 0);
        checkOutput("resetData", wr_data, 0);
        rst = 1'b0;

        // Reset in the middle of a long frame
        applyStimulus(FX_ZERO, FX_ZERO, FX_ZERO);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midResetWrEn", wr_en, 0);
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetDone", done, 0);
        checkOutput("midResetAddr", wr_addr, 0);
        repeat (2) @(negedge clk);
        checkOutput("midResetBusyHeld", busy, 0);
        rst = 1'b0;
        activity = 0;
        repeat (300) begin
            @(negedge clk);
            if (wr_en || busy || done) activity++;
        end
        checkOutput("idleAfterReset", activity, 0);

        // Reset while a write is pending
        applyStimulus(FX_THREE, FX_ZERO, FX_ZERO);
        wr_ready = 1'b0;
        sawWrEn  = 1'b0;
        for (int i = 0; i < 50 && !sawWrEn; i++) begin
            @(negedge clk);
            if (wr_en) sawWrEn = 1'b1;
        end
        checkOutput("wrEnBeforeReset", sawWrEn, 1);
        checkOutput("pendingData", wr_data, 1);
        rst = 1'b1;
        #1;
        checkOutput("pendResetWrEn", wr_en, 0);
        checkOutput("pendResetData", wr_data, 0);
        checkOutput("pendResetBusy", busy, 0);
        @(negedge clk);
        rst      = 1'b0;
        wr_ready = 1'b1;
        activity = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en) activity++;
        end
        checkOutput("noWritesAfterPendReset", activity, 0);

        // Table-driven full frames
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].cx, vecs[v].cy, vecs[v].st);
            collectFrame(-1, 8'd0, -1, FX_ZERO, FX_ZERO, FX_ZERO);
            expectPlain(vecs[v]);
            verifyFrame();
        end

        // Backpressure at address 2
        applyStimulus(vecs[1].cx, vecs[1].cy, vecs[1].st);
        collectFrame(2, 8'd1, -1, FX_ZERO, FX_ZERO, FX_ZERO);
        expectPlain(vecs[1]);
        verifyFrame();

        // Start pulse while address 3 is pending; new view c=(1,1) escapes with count 2
        applyStimulus(vecs[1].cx, vecs[1].cy, vecs[1].st);
        collectFrame(-1, 8'd0, 3, FX_ONE, FX_ONE, FX_ZERO);
        expAddr.delete();
        expData.delete();
`ifdef FRACT_RESTART_EN
        for (int i = 0; i < 3; i++) begin
            expAddr.push_back(i);
            expData.push_back(1);
        end
        for (int i = 0; i < NPIX; i++) begin
            expAddr.push_back(i);
            expData.push_back(2);
        end
`else
        for (int i = 0; i < NPIX; i++) begin
            expAddr.push_back(i);
            expData.push_back(1);
        end
`endif
        verifyFrame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
